// File: rtl/io_bus.sv
// io_bus: memory-mapped I/O decoder for a 16-bit processor -- external memory
// pass-through, LED and HEX output registers, synchronized switches and a timer.
module io_bus #(
  parameter int LED_W  = 10,
  parameter int MEM_AW = 12
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DOUT,
  input  logic              W,
  output logic [15:0]       DIN,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_wren,
  input  logic [15:0]       mem_q,
  input  logic [LED_W-1:0]  SW,
  output logic [LED_W-1:0]  LEDR,
  output logic [41:0]       HEX
);

  localparam logic [3:0] RGN_MEM = 4'h0;
  localparam logic [3:0] RGN_LED = 4'h1;
  localparam logic [3:0] RGN_HEX = 4'h2;
  localparam logic [3:0] RGN_SW  = 4'h3;
  localparam logic [3:0] RGN_TMR = 4'h4;

  localparam logic [1:0] TMR_LOAD   = 2'd0;
  localparam logic [1:0] TMR_CTRL   = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  // Bus protocol: ADDR/DOUT/W describe one access per cycle, never stalled.
  // W=1 commits at the edge; DIN holds the read data of cycle n's ADDR during cycle n+1.

  logic [3:0]       region;
  logic             load_wr, ctrl_wr, stat_wr, expire;

  logic [LED_W-1:0] led_q, led_d;
  logic [41:0]      hex_q, hex_d;
  logic [LED_W-1:0] sw_meta_q, sw_sync_q;
  logic [15:0]      load_q, load_d;
  logic [15:0]      count_q, count_d;
  logic             en_q, en_d;
  logic             auto_q, auto_d;
  logic             expired_q, expired_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_mem_q, rd_mem_d;

  assign region   = ADDR[15:12];
  assign mem_addr = ADDR[MEM_AW-1:0];
  assign mem_wren = W & (region == RGN_MEM);

  assign load_wr = W & (region == RGN_TMR) & (ADDR[1:0] == TMR_LOAD);
  assign ctrl_wr = W & (region == RGN_TMR) & (ADDR[1:0] == TMR_CTRL);
  assign stat_wr = W & (region == RGN_TMR) & (ADDR[1:0] == TMR_STATUS);
  assign expire  = en_q & ~load_wr & (count_q == 16'd0);

  always_comb begin
    led_d = led_q;
    hex_d = hex_q;
    if (W && region == RGN_LED) led_d = DOUT[LED_W-1:0];
    for (int k = 0; k < 6; k++) begin
      if (W && region == RGN_HEX && ADDR[2:0] == 3'(k)) hex_d[7*k +: 7] = DOUT[6:0];
    end
  end

  // LOAD write beats the countdown; CTRL write beats the one-shot auto-clear of EN;
  // an expiry beats a STATUS clear in the same edge.
  always_comb begin
    load_d    = load_q;
    count_d   = count_q;
    en_d      = en_q;
    auto_d    = auto_q;
    expired_d = expired_q;
    if (load_wr) begin
      load_d  = DOUT;
      count_d = DOUT;
    end else if (en_q) begin
      if (count_q != 16'd0) count_d = count_q - 16'd1;
      else if (auto_q)      count_d = load_q;
      else                  en_d    = 1'b0;
    end
    if (ctrl_wr) begin
      en_d   = DOUT[0];
      auto_d = DOUT[1];
    end
    if (stat_wr && DOUT[0]) expired_d = 1'b0;
    if (expire)             expired_d = 1'b1;
  end

  always_comb begin
    rd_data_d = 16'h0000;
    rd_mem_d  = (region == RGN_MEM);
    case (region)
      RGN_LED: rd_data_d[LED_W-1:0] = led_q;
      RGN_HEX: begin
        for (int k = 0; k < 6; k++) begin
          if (ADDR[2:0] == 3'(k)) rd_data_d[6:0] = hex_q[7*k +: 7];
        end
      end
      RGN_SW:  rd_data_d[LED_W-1:0] = sw_sync_q;
      RGN_TMR: begin
        case (ADDR[1:0])
          TMR_LOAD:   rd_data_d = load_q;
          TMR_CTRL:   rd_data_d = {14'd0, auto_q, en_q};
          TMR_COUNT:  rd_data_d = count_q;
          TMR_STATUS: rd_data_d = {15'd0, expired_q};
          default:    rd_data_d = 16'h0000;
        endcase
      end
      default: rd_data_d = 16'h0000;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      led_q     <= '0;
      hex_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      load_q    <= '0;
      count_q   <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
      rd_data_q <= '0;
      rd_mem_q  <= 1'b0;
    end else begin
      led_q     <= led_d;
      hex_q     <= hex_d;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      load_q    <= load_d;
      count_q   <= count_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      expired_q <= expired_d;
      rd_data_q <= rd_data_d;
      rd_mem_q  <= rd_mem_d;
    end
  end

  assign DIN  = rd_mem_q ? mem_q : rd_data_q;
  assign LEDR = led_q;
  assign HEX  = hex_q;

endmodule

// File: tb/tb_io_bus.sv
// Bench for io_bus: directed scenarios followed by random bus traffic, checked
// against a behavioural model of the address map, timer and external memory.
module tb_io_bus;

  logic        Clock, Reset;
  logic [15:0] ADDR, DOUT, DIN, mem_q;
  logic        W, mem_wren;
  logic [11:0] mem_addr;
  logic [9:0]  SW, LEDR;
  logic [41:0] HEX;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [15:0] exp_q[$];

  io_bus #(.LED_W(10), .MEM_AW(12)) dut (
    .Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(DIN),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_q(mem_q), .SW(SW),
    .LEDR(LEDR), .HEX(HEX)
  );

  // ---- clock / external memory ----
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  logic [15:0] ext_mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ext_mem[i] = 16'h0000;
    mem_q = 16'h0000;
  end
  always @(posedge Clock) begin
    mem_q <= ext_mem[mem_addr];
    if (mem_wren) ext_mem[mem_addr] = DOUT;
  end

  // ---- behavioural model ----
  logic [15:0] m_mem [4096];
  logic [9:0]  m_led, m_sw1, m_sw2;
  logic [6:0]  m_hex [6];
  logic [15:0] m_load, m_count;
  logic        m_en, m_auto, m_exp;

  task automatic model_reset();
    m_led = 0; m_sw1 = 0; m_sw2 = 0;
    for (int k = 0; k < 6; k++) m_hex[k] = 0;
    m_load = 0; m_count = 0; m_en = 0; m_auto = 0; m_exp = 0;
  endtask

  function automatic logic [41:0] model_hex();
    logic [41:0] r;
    for (int k = 0; k < 6; k++) r[7*k +: 7] = m_hex[k];
    return r;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    case (a[15:12])
      4'h0: return m_mem[a[11:0]];
      4'h1: return {6'd0, m_led};
      4'h2: return (a[2:0] < 3'd6) ? {9'd0, m_hex[a[2:0]]} : 16'h0000;
      4'h3: return {6'd0, m_sw2};
      4'h4: begin
        case (a[1:0])
          2'd0:    return m_load;
          2'd1:    return {14'd0, m_auto, m_en};
          2'd2:    return m_count;
          default: return {15'd0, m_exp};
        endcase
      end
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step(input logic [15:0] a, input logic [15:0] d, input logic w);
    logic tmr, lw, fires;
    tmr   = w && (a[15:12] == 4'h4);
    lw    = tmr && (a[1:0] == 2'd0);
    fires = m_en && !lw && (m_count == 0);
    if (w && a[15:12] == 4'h0) m_mem[a[11:0]] = d;
    if (w && a[15:12] == 4'h1) m_led = d[9:0];
    if (w && a[15:12] == 4'h2 && a[2:0] < 3'd6) m_hex[a[2:0]] = d[6:0];
    m_sw2 = m_sw1;
    m_sw1 = SW;
    if (lw) begin
      m_load = d; m_count = d;
    end else if (m_en && m_count > 0) begin
      m_count = m_count - 1;
    end else if (fires && m_auto) begin
      m_count = m_load;
    end
    if (fires && !m_auto) m_en = 0;
    if (tmr && a[1:0] == 2'd1) begin
      m_en = d[0]; m_auto = d[1];
    end
    if (tmr && a[1:0] == 2'd3 && d[0]) m_exp = 0;
    if (fires) m_exp = 1;
  endtask

  // ---- scoreboard ----
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---- drivers (called at the falling edge) ----
  task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic w);
    ADDR = a; DOUT = d; W = w;
    #1;
    check("mem_wren", {47'd0, mem_wren}, {47'd0, w && (a[15:12] == 4'h0)});
    check("mem_addr", {36'd0, mem_addr}, {36'd0, a[11:0]});
    exp_q.push_back(model_read(a));
    model_step(a, d, w);
    @(posedge Clock);
    @(negedge Clock);
    check("DIN", {32'd0, DIN}, {32'd0, exp_q.pop_front()});
    check("LEDR", {38'd0, LEDR}, {38'd0, m_led});
    check("HEX", {6'd0, HEX}, {6'd0, model_hex()});
  endtask

  task automatic do_reset();
    Reset = 1'b1; W = 1'b0; ADDR = 16'h0000; DOUT = 16'h0000;
    model_reset();
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    check("rst_DIN", {32'd0, DIN}, 48'd0);
    check("rst_LEDR", {38'd0, LEDR}, 48'd0);
    check("rst_HEX", {6'd0, HEX}, 48'd0);
  endtask

  initial begin
    logic [15:0] a, d;
    logic        w;
    for (int i = 0; i < 4096; i++) m_mem[i] = 16'h0000;
    SW = 10'd0;
    do_reset();

    // LED write and readback
    cycle(16'h1000, 16'h03FF, 1'b1);
    check("led_write", {38'd0, LEDR}, {38'd0, 10'h3FF});
    cycle(16'h1000, 16'h0000, 1'b0);
    check("led_read", {32'd0, DIN}, {32'd0, 16'h03FF});

    // HEX display 5, then ignored index 6
    cycle(16'h2005, 16'h007F, 1'b1);
    check("hex5_write", {41'd0, HEX[41:35]}, {41'd0, 7'h7F});
    cycle(16'h2006, 16'h0055, 1'b1);
    check("hex6_ignored", {6'd0, HEX}, {6'd0, 7'h7F, 35'd0});

    // memory path
    cycle(16'h0123, 16'hBEEF, 1'b1);
    cycle(16'h5000, 16'h1234, 1'b1);
    cycle(16'h0123, 16'h0000, 1'b0);
    check("mem_read", {32'd0, DIN}, {32'd0, 16'hBEEF});

    // one-shot timer
    cycle(16'h4000, 16'd3, 1'b1);
    cycle(16'h4001, 16'h0001, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      cycle(16'h4002, 16'h0000, 1'b0);
      check("oneshot_count", {32'd0, DIN}, 48'(i));
    end
    cycle(16'h4003, 16'h0000, 1'b0);
    check("oneshot_status", {32'd0, DIN}, 48'd1);
    cycle(16'h4001, 16'h0000, 1'b0);
    check("oneshot_en_clear", {32'd0, DIN}, 48'd0);
    cycle(16'h4003, 16'h0001, 1'b1);
    cycle(16'h4003, 16'h0000, 1'b0);
    check("status_cleared", {32'd0, DIN}, 48'd0);

    // auto-reload timer and set-over-clear
    cycle(16'h4000, 16'd2, 1'b1);
    cycle(16'h4001, 16'h0003, 1'b1);
    for (int i = 0; i < 3; i++) cycle(16'h4003, 16'h0000, 1'b0);
    check("auto_not_yet", {32'd0, DIN}, 48'd0);
    cycle(16'h4002, 16'h0000, 1'b0);
    check("auto_reload", {32'd0, DIN}, 48'd2);
    cycle(16'h4003, 16'h0000, 1'b0);
    check("auto_expired", {32'd0, DIN}, 48'd1);
    cycle(16'h4003, 16'h0001, 1'b1);
    cycle(16'h4003, 16'h0000, 1'b0);
    check("set_beats_clear", {32'd0, DIN}, 48'd1);
    cycle(16'h4003, 16'h0001, 1'b1);
    cycle(16'h4003, 16'h0000, 1'b0);
    check("clear_no_expiry", {32'd0, DIN}, 48'd0);

    // switch synchronizer
    SW = 10'h2A5;
    for (int i = 0; i < 3; i++) cycle(16'h3000, 16'h0000, 1'b0);
    check("sw_read", {32'd0, DIN}, {32'd0, 16'h02A5});

    // reset mid-countdown
    cycle(16'h4000, 16'd20, 1'b1);
    cycle(16'h4001, 16'h0001, 1'b1);
    cycle(16'h4002, 16'h0000, 1'b0);
    do_reset();
    cycle(16'h4002, 16'h0000, 1'b0);
    check("rst_count", {32'd0, DIN}, 48'd0);
    cycle(16'h4001, 16'h0000, 1'b0);
    check("rst_ctrl", {32'd0, DIN}, 48'd0);
    cycle(16'h4003, 16'h0000, 1'b0);
    check("rst_status", {32'd0, DIN}, 48'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) SW = 10'($urandom);
      d = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      case ($urandom_range(0, 6))
        0: a = {4'h0, 8'h00, a[3:0]};
        1: a = {4'h1, a[11:0]};
        2: a = {4'h2, a[11:0]};
        3: a = {4'h3, a[11:0]};
        4, 5: begin
          a = {4'h4, a[11:0]};
          if (a[1:0] == 2'd0) d = 16'($urandom_range(0, 6));
        end
        default: a[15:12] = 4'($urandom_range(5, 15));
      endcase
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle(a, d, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/io_bus.md
IO_BUS -- requirements
Module: io_bus

Interface
REQ-001 Parameter LED_W, default 10, width of LEDR register and SW input.
REQ-002 Parameter MEM_AW, default 12, word-address width of external synchronous memory.
REQ-003 Clock  in  1  single system clock; all state updates on posedge Clock.
REQ-004 Reset  in  1  reset, synchronous, active-high.
REQ-005 ADDR  in  16  processor address register output.
REQ-006 DOUT  in  16  processor write-data register output.
REQ-007 W  in  1  processor write strobe; ADDR, DOUT and W are valid in the same cycle.
REQ-008 DIN  out  16  read data returned to the processor.
REQ-009 mem_addr  out  MEM_AW  ADDR[MEM_AW-1:0], combinational.
REQ-010 mem_wren  out  1  memory write enable, combinational.
REQ-011 mem_q  in  16  memory read data, one cycle after mem_addr.
REQ-012 SW  in  LED_W  asynchronous slide-switch inputs.
REQ-013 LEDR  out  LED_W  LED register.
REQ-014 HEX  out  42  six 7-bit display registers, HEX[7k+6:7k] = display k.

Function
REQ-015 Address map decoded on ADDR[15:12]: 0x0 memory; 0x1 LEDR; 0x2 HEX (ADDR[2:0]=0..5); 0x3 SW; 0x4 timer (ADDR[1:0]); all other addresses unmapped.
REQ-016 mem_wren = W & (ADDR[15:12]==0).
REQ-017 Write to LEDR when W & sel: LEDR <= DOUT[LED_W-1:0].
REQ-018 Write to HEX k when W & sel & ADDR[2:0]==k, k<=5: display k <= DOUT[6:0]; ADDR[2:0]=6,7 ignored.
REQ-019 Writes to SW, unmapped addresses, or read-only timer registers have no effect.
REQ-020 SW passes through a 2-flop synchronizer; readback returns the second flop, zero-extended.
REQ-021 Read latency is one cycle: DIN in cycle n+1 reflects ADDR from cycle n; processor samples it in a later cycle.
REQ-022 Memory region selects mem_q; every other region selects a registered value; the region select is registered alongside.
REQ-023 Readback: LEDR, HEX k and SW are zero-extended; unmapped reads return 0x0000.
REQ-024 Timer registers: 0x4000 LOAD (R/W, 16b); 0x4001 CTRL (R/W, bit0 EN, bit1 AUTO); 0x4002 COUNT (RO); 0x4003 STATUS (bit0 EXP, write 1 clears).
REQ-025 A write to LOAD sets LOAD <= DOUT and COUNT <= DOUT in the same edge.
REQ-026 Timer step, each edge with EN=1 and no LOAD write: if COUNT!=0 then COUNT <= COUNT-1.
REQ-027 If COUNT==0 instead: EXP <= 1; then COUNT <= LOAD if AUTO=1, else EN <= 0 and COUNT holds 0.
REQ-028 Priority on COUNT: LOAD write > timer step.
REQ-029 Priority on EN: CTRL write > auto-clear of REQ-027.
REQ-030 Priority on EXP: expiry set > STATUS write-1 clear in the same edge.
REQ-031 COUNT wraps never: no decrement below 0; period with AUTO=1 is LOAD+1 cycles.
REQ-032 A read of COUNT returns the value before that edge's update.

Reset
REQ-033 While Reset=1 at a posedge, LEDR, HEX, LOAD, COUNT, CTRL, EXP, the synchronizer flops, the registered read data and the region select clear to 0.
REQ-034 Consequently DIN=0x0000 in the cycle after reset; mem_wren stays combinational and is unaffected by reset.
REQ-035 Reset mid-countdown aborts the timer: EN=0, COUNT=0, EXP=0, with no expiry event.

Verification
REQ-036 Write: ADDR=0x1000, DOUT=0x03FF, W=1 for one cycle -> LEDR=0x3FF next cycle; read 0x1000 -> DIN=0x03FF one cycle later.
REQ-037 Write: ADDR=0x2005, DOUT=0x007F, W=1 -> HEX[41:35]=7'h7F; other displays are unchanged; then ADDR=0x2006, W=1 -> no change.
REQ-038 Memory: ADDR=0x0123, W=1 -> mem_wren=1, mem_addr=0x123; ADDR=0x5000, W=1 -> mem_wren=0; ADDR=0x0123 read, mem_q=0xBEEF -> DIN=0xBEEF.
REQ-039 Timer one-shot: LOAD=3, CTRL=0x1 -> COUNT 3,2,1,0; then EXP=1 and EN=0; STATUS read = 0x0001; write STATUS=1 -> EXP=0.
REQ-040 Timer auto-reload: LOAD=2, CTRL=0x3 -> EXP first set after 3 enabled cycles; COUNT reloads to 2; a STATUS clear coinciding with expiry leaves EXP=1.
REQ-041 Switches: SW=0x2A5 -> read 0x3000 returns 0x02A5 within 3 cycles; Reset=1 during a countdown -> COUNT=0, CTRL=0 next cycle.
